// File: rtl/ws2812_pkg.sv
// Shared types and default sizing for the WS2812 frame buffer path.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } ws2812_state_e;

  localparam int WS_LED_NUM  = 16;
  localparam int WS_CHANNELS = 3;
  localparam int WS_CH_WIDTH = 8;

endpackage

// File: rtl/ws2812_bank_ram.sv
// Simple dual-port colour RAM: per-channel write enables, registered read.
// Contents are intentionally not reset.
module ws2812_bank_ram #(
  parameter int CHANNELS = 3,
  parameter int CH_WIDTH = 8,
  parameter int AW       = 5
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [CHANNELS*CH_WIDTH-1:0] wdata,
  input  logic [CHANNELS-1:0]          wbe,
  input  logic [AW-1:0]                raddr,
  output logic [CHANNELS*CH_WIDTH-1:0] rdata
);

  localparam int DW    = CHANNELS * CH_WIDTH;
  // Full power-of-two span of {bank, index}; entries past LED_NUM are never written.
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Channel-masked write and registered read on the same clock.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (we && wbe[c]) mem[waddr][c*CH_WIDTH +: CH_WIDTH] <= wdata[c*CH_WIDTH +: CH_WIDTH];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered LED frame store. Host writes the back bank, the stream
// reads the front bank; banks swap only while the stream is idle.
module ws2812_frame_buffer
  import ws2812_pkg::*;
#(
  parameter int LED_NUM    = WS_LED_NUM,
  parameter int CHANNELS   = WS_CHANNELS,
  parameter int CH_WIDTH   = WS_CH_WIDTH,
  parameter int DATA_WIDTH = CHANNELS * CH_WIDTH,
  parameter int ADDR_WIDTH = $clog2(LED_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [CHANNELS-1:0]   wr_be,
  input  logic                  swap_req,
  input  logic                  rd_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  front_sel
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LED_NUM - 1);
  localparam logic [ADDR_WIDTH:0]   LED_LIMIT = (ADDR_WIDTH + 1)'(LED_NUM);

  ws2812_state_e         state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  ld;        // RAM read data is valid this cycle
  logic                  wr_ok;
  logic                  hs;
  logic                  swap_now;
  logic [DATA_WIDTH-1:0] rdata;

  assign wr_ok    = wr_en && ({1'b0, wr_addr} < LED_LIMIT);
  assign hs       = out_valid && out_ready;
  assign swap_now = (state == IDLE) && (swap_pending || swap_req);
  assign busy     = (state != IDLE);

  // Writes use the pre-edge front_sel, so a write coincident with a swap
  // lands in the bank that is about to become the front.
  ws2812_bank_ram #(
    .CHANNELS (CHANNELS),
    .CH_WIDTH (CH_WIDTH),
    .AW       (ADDR_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr ({~front_sel, wr_addr}),
    .wdata (wr_data),
    .wbe   (wr_be),
    .raddr ({front_sel, idx}),
    .rdata (rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> FETCH on start, FETCH -> HOLD, HOLD waits for handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_start) state_nxt = FETCH;
      FETCH:   state_nxt = HOLD;
      HOLD:    if (hs) state_nxt = out_last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Index counter and output register; out_data/out_last hold until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      ld        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      ld <= (state == FETCH);
      if (state == IDLE && rd_start) idx <= '0;
      else if (state == HOLD && hs && !out_last) idx <= idx + 1'b1;
      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= rdata;
        out_last  <= (idx == LAST_IDX);
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Swap: requests merge into one pending flag, applied only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (swap_now) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Scoreboard bench for ws2812_frame_buffer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_ws2812_frame_buffer;

  localparam int LN = 16;
  localparam int AW = 4;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [2:0]    wr_be = '0;
  logic          swap_req = 1'b0;
  logic          rd_start = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          swap_pending;
  logic          swap_done;
  logic          front_sel;

  ws2812_frame_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .swap_req     (swap_req),
    .rd_start     (rd_start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_sel    (front_sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;
  logic [DW:0]   exp_q [$];      // {last, data}
  logic [DW-1:0] mdl [2][LN];    // bank model
  logic          mfront = 1'b0;
  logic          rnd = 1'b0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: stability while stalled, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (held_v) begin
          n_tests++;
          if (out_data !== held_d || out_last !== held_l) begin
            n_fail++;
            $display("FAIL hold_stable: got %h/%b expected %h/%b", out_data, out_last, held_d, held_l);
          end
        end
        held_v = 1'b1;
        held_d = out_data;
        held_l = out_last;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got %h expected none", out_data);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            n_fail++;
            $display("FAIL beat%0d: got %b/%h expected %b/%h", beats, out_last, out_data, e[DW], e[DW-1:0]);
          end
        end
        beats++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [2:0] be);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
    for (int c = 0; c < 3; c++)
      if (be[c]) mdl[~mfront][a][c*8 +: 8] = d[c*8 +: 8];
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < LN; i++) exp_q.push_back({(i == LN - 1), mdl[mfront][i]});
    beats = 0;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    mfront = ~mfront;
    chk("swap_front", 32'(front_sel), 32'(mfront));
    chk("swap_done_hi", 32'(swap_done), 1);
    chk("swap_pend_clr", 32'(swap_pending), 0);
  endtask

  task automatic start_stream();
    push_frame();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("busy_on_start", 32'(busy), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("stream_done", 32'(exp_q.size()), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  task automatic wait_beats(input int b);
    int n = 0;
    while (beats < b && n < 200) begin tick(); n++; end
    chk("reach_beat", 32'(beats >= b), 1);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_front", 32'(front_sel), 0);
    chk("rst_pend", 32'(swap_pending), 0);
    chk("rst_done", 32'(swap_done), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    rst_n = 1'b1;
    tick();

    // Full frame 0x010203*i into bank 1, swap, pattern into bank 0
    for (int i = 0; i < LN; i++) wr(i, DW'(32'h010203 * i), 3'b111);
    swap();
    tick();
    chk("swap_done_pulse", 32'(swap_done), 0);
    for (int i = 0; i < LN; i++) wr(i, DW'(32'h100000 + i * 17), 3'b111);

    // Stream with latency checks
    start_stream();
    chk("lat_k", 32'(out_valid), 0);
    tick();
    chk("lat_k1", 32'(out_valid), 0);
    tick();
    chk("lat_k2", 32'(out_valid), 1);
    chk("lat_data0", 32'(out_data), 0);
    wait_idle(200);
    chk("beats16", 32'(beats), 16);

    // Partial write and no-copy bank behaviour
    wr(3, 24'hAABBCC, 3'b111);
    swap();                               // front = 0
    start_stream(); wait_idle(200);
    wr(3, 24'h00EE00, 3'b010);            // bank 1 LED3: 0x030609 -> 0x03EE09
    swap(); swap();                       // front = 0 again
    chk("led3_front0", 32'(mdl[0][3]), 32'hAABBCC);
    start_stream(); wait_idle(200);
    swap();                               // front = 1
    chk("led3_front1", 32'(mdl[1][3]), 32'h03EE09);
    start_stream(); wait_idle(200);

    // Swap requested mid-stream is deferred to the first idle cycle
    start_stream();
    wait_beats(5);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("mid_pend", 32'(swap_pending), 1);
    chk("mid_front_hold", 32'(front_sel), 32'(mfront));
    wait_idle(200);
    chk("mid_pend_idle", 32'(swap_pending), 1);
    chk("mid_no_done", 32'(swap_done), 0);
    tick();
    mfront = ~mfront;
    chk("mid_front_tog", 32'(front_sel), 32'(mfront));
    chk("mid_done", 32'(swap_done), 1);
    chk("mid_pend_clr", 32'(swap_pending), 0);
    tick();
    chk("mid_done_once", 32'(swap_done), 0);

    // Random backpressure
    rnd = 1'b1;
    start_stream(); wait_idle(600);
    rnd = 1'b0;
    chk("rnd_beats", 32'(beats), 16);

    // Swap and start in the same idle cycle: new front is streamed
    for (int i = 0; i < LN; i++) wr(i, DW'(32'h5A0000 | i), 3'b111);
    swap_req = 1'b1; rd_start = 1'b1;
    mfront = ~mfront;
    push_frame();
    tick();
    swap_req = 1'b0; rd_start = 1'b0;
    chk("same_front", 32'(front_sel), 32'(mfront));
    chk("same_done", 32'(swap_done), 1);
    chk("same_busy", 32'(busy), 1);
    wait_idle(200);

    // Reset mid-stream
    start_stream();
    wait_beats(7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_front", 32'(front_sel), 0);
    chk("arst_data", 32'(out_data), 0);
    exp_q.delete();
    mfront = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_stream(); wait_idle(200);
    chk("post_rst_beats", 32'(beats), 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
